// File: rtl/cpu_pipeline_ctrl.sv
// Pipeline sequencer: merges stage stall requests, flushes on exception/ERET and
// holds PC redirects (exception target or ID branch) until IF acknowledges them.
module cpu_pipeline_ctrl #(
  parameter int unsigned PERF_W   = 32,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall_req_if,
  input  logic              stall_req_id,
  input  logic              stall_req_ex,
  input  logic              stall_req_mem,
  input  logic              exc_valid,
  input  logic [31:0]       exc_target,
  input  logic              branch_valid,
  input  logic [31:0]       branch_addr,
  input  logic              redirect_ack,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {ST_RUN, ST_REDIR} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_tgt;
  logic [31:0]       w_tgt_nxt;
  logic              r_br_pend;
  logic              w_br_pend_nxt;
  logic [PERF_W-1:0] r_stall_cycles;
  logic [5:0]        w_stall_req;

  // The most downstream requester freezes itself and everything upstream.
  always_comb begin
    w_stall_req = 6'b000000;
    if (stall_req_mem)     w_stall_req = 6'b011111;
    else if (stall_req_ex) w_stall_req = 6'b001111;
    else if (stall_req_id) w_stall_req = 6'b000111;
    else if (stall_req_if) w_stall_req = 6'b000011;
  end

  // r_tgt holds the exception target in REDIR, or the pending branch target in RUN.
  always_comb begin
    w_state_nxt    = r_state;
    w_tgt_nxt      = r_tgt;
    w_br_pend_nxt  = r_br_pend;
    stall          = w_stall_req;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = r_tgt;
    if (!resetn) begin
      stall = 6'b000000;
    end else if (exc_valid) begin
      flush          = 1'b1;
      stall          = 6'b000000;
      redirect_valid = (r_state == ST_REDIR);
      w_state_nxt    = ST_REDIR;
      w_tgt_nxt      = exc_target;
      w_br_pend_nxt  = 1'b0;
    end else if (r_state == ST_REDIR) begin
      redirect_valid = 1'b1;
      if (redirect_ack) w_state_nxt = ST_RUN;
    end else if (r_br_pend) begin
      redirect_valid = 1'b1;
      if (redirect_ack) w_br_pend_nxt = 1'b0;
    end else if (branch_valid) begin
      if (!w_stall_req[2]) begin
        redirect_valid = 1'b1;
        redirect_pc    = branch_addr;
      end
      if (w_stall_req[2] || !redirect_ack) begin
        w_br_pend_nxt = 1'b1;
        w_tgt_nxt     = branch_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_RUN;
      r_tgt     <= RESET_PC;
      r_br_pend <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tgt     <= w_tgt_nxt;
      r_br_pend <= w_br_pend_nxt;
    end
  end

  // Saturating count of stalled cycles; flush cycles carry stall=0 and are skipped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cycles <= '0;
    end else if ((|stall) && (r_stall_cycles != {PERF_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_cpu_pipeline_ctrl.sv
// Scoreboard bench for cpu_pipeline_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the redirect/stall rules.
module tb_cpu_pipeline_ctrl;

  localparam int unsigned PERF_W   = 5;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam int          CNT_MAX  = (1 << PERF_W) - 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic              stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic              exc_valid;
  logic [31:0]       exc_target;
  logic              branch_valid;
  logic [31:0]       branch_addr;
  logic              redirect_ack;
  logic [5:0]        stall;
  logic              flush;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [PERF_W-1:0] stall_cycles;

  typedef struct packed {
    logic [5:0]        stall;
    logic              flush;
    logic              rv;
    logic [31:0]       pc;
    logic [PERF_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  bit          m_in_exc;
  logic [31:0] m_exc_pc;
  bit          m_br_pend;
  logic [31:0] m_br_pc;
  int          m_cnt;

  cpu_pipeline_ctrl #(.PERF_W(PERF_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn),
    .stall_req_if(stall_req_if), .stall_req_id(stall_req_id),
    .stall_req_ex(stall_req_ex), .stall_req_mem(stall_req_mem),
    .exc_valid(exc_valid), .exc_target(exc_target),
    .branch_valid(branch_valid), .branch_addr(branch_addr),
    .redirect_ack(redirect_ack),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_exc  = 0;
    m_exc_pc  = RESET_PC;
    m_br_pend = 0;
    m_br_pc   = 32'h0;
    m_cnt     = 0;
  endtask

  // Called at posedge+1: drive one cycle, predict outputs, advance the model.
  task automatic step(input bit [3:0] req, input bit exc, input logic [31:0] exc_t,
                      input bit br, input logic [31:0] br_a, input bit ack);
    exp_t e;
    int   lvl;
    {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if} = req;
    exc_valid    = exc;
    exc_target   = exc_t;
    branch_valid = br;
    branch_addr  = br_a;
    redirect_ack = ack;
    lvl = req[3] ? 5 : req[2] ? 4 : req[1] ? 3 : req[0] ? 2 : 0;
    e.stall = 6'((1 << lvl) - 1);
    e.flush = 1'b0;
    e.rv    = 1'b0;
    e.pc    = 32'h0;
    e.cnt   = PERF_W'(m_cnt);
    if (exc) begin
      e.flush = 1'b1;
      e.stall = 6'b0;
      e.rv    = m_in_exc;
      e.pc    = m_exc_pc;
      m_in_exc  = 1;
      m_exc_pc  = exc_t;
      m_br_pend = 0;
    end else if (m_in_exc) begin
      e.rv = 1'b1;
      e.pc = m_exc_pc;
      if (ack) m_in_exc = 0;
    end else if (m_br_pend) begin
      e.rv = 1'b1;
      e.pc = m_br_pc;
      if (ack) m_br_pend = 0;
    end else if (br) begin
      if (lvl < 3) begin
        e.rv = 1'b1;
        e.pc = br_a;
        if (!ack) begin
          m_br_pend = 1;
          m_br_pc   = br_a;
        end
      end else begin
        m_br_pend = 1;
        m_br_pc   = br_a;
      end
    end
    if (e.stall != 6'b0 && m_cnt < CNT_MAX) m_cnt++;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each predicted cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("stall", 32'(stall), 32'(e.stall));
      check("flush", 32'(flush), 32'(e.flush));
      check("redirect_valid", 32'(redirect_valid), 32'(e.rv));
      if (e.rv) check("redirect_pc", redirect_pc, e.pc);
      check("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'h0);
    check({tag, "_flush"}, 32'(flush), 32'h0);
    check({tag, "_rv"}, 32'(redirect_valid), 32'h0);
    check({tag, "_pc"}, redirect_pc, RESET_PC);
    check({tag, "_cnt"}, 32'(stall_cycles), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if} = 4'b0;
    exc_valid = 0; exc_target = 0; branch_valid = 0; branch_addr = 0; redirect_ack = 0;
    model_reset();
    #12;
    check_reset_vals("reset");
    @(posedge clk); #1;
    resetn = 1'b1;

    // T1: id+if -> id wins
    step(4'b0011, 0, 32'h0, 0, 32'h0, 0);
    // T2: mem+ex for three cycles
    repeat (3) step(4'b1100, 0, 32'h0, 0, 32'h0, 0);
    // T3: exception beats mem stall, redirect held 4 cycles
    step(4'b1000, 1, 32'hBFC00380, 0, 32'h0, 0);
    repeat (4) step(4'b0000, 0, 32'h0, 0, 32'h0, 0);
    step(4'b0000, 0, 32'h0, 0, 32'h0, 1);
    step(4'b0000, 0, 32'h0, 0, 32'h0, 0);
    // T4: branch under id stall goes pending
    step(4'b0010, 0, 32'h0, 1, 32'h80001000, 0);
    step(4'b0000, 0, 32'h0, 1, 32'h80002000, 0);
    step(4'b0000, 0, 32'h0, 0, 32'h0, 0);
    step(4'b0000, 0, 32'h0, 0, 32'h0, 1);
    step(4'b0000, 0, 32'h0, 0, 32'h0, 0);
    // T5: exception drops pending branch
    step(4'b0010, 0, 32'h0, 1, 32'h80001000, 0);
    step(4'b0000, 1, 32'hBFC00380, 0, 32'h0, 0);
    step(4'b0000, 0, 32'h0, 0, 32'h0, 1);
    // Unstalled branch taken and acked in the same cycle
    step(4'b0001, 0, 32'h0, 1, 32'h80003000, 1);
    step(4'b0000, 0, 32'h0, 0, 32'h0, 0);

    for (int i = 0; i < 1500; i++) begin
      bit [3:0] req;
      for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 3) == 0);
      step(req, ($urandom_range(0, 15) == 0), $urandom(),
           ($urandom_range(0, 4) == 0), $urandom(), ($urandom_range(0, 1) == 1));
    end

    // T6: reset while in REDIR
    step(4'b0000, 1, 32'hBFC00380, 0, 32'h0, 0);
    step(4'b0000, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk); #1;
    {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if} = 4'b0;
    exc_valid = 0; branch_valid = 0; redirect_ack = 0;
    resetn = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
    repeat (2) step(4'b0000, 0, 32'h0, 0, 32'h0, 0);
    step(4'b0100, 0, 32'h0, 0, 32'h0, 0);

    @(negedge clk); #1;
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
